// File: rtl/cache_controller_pkg.sv
// Shared types and address-slicing constants for the cache controller.
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    localparam int TAG_W     = 26;
    localparam int INDEX_W   = 2;
    localparam int BLOCK_W   = 128;
    localparam int TAG_LSB   = 6;
    localparam int INDEX_LSB = 4;
    localparam int WORD_LSB  = 2;

    function automatic logic [31:0] block_addr(input logic [31:0] addr);
        return {addr[31:4], 4'b0000};
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU load/store port: the CPU side is master, the controller is slave.
interface cache_controller_if;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_byte;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;

    modport master (
        output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign value = count_reg;
endmodule

// File: rtl/cache_controller.sv
// Miss sequencer for a 4-line direct-mapped write-back cache: dirty
// writeback, then block fill, then the re-lookup that completes the access.
module cache_controller
    import cache_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    cache_controller_if.slave    cpu,
    output logic                 c_write_word,
    output logic                 c_write_block,
    output logic                 c_byte_access,
    output logic [INDEX_W-1:0]   c_index,
    output logic [1:0]           c_word,
    output logic [1:0]           c_byte,
    output logic [TAG_W-1:0]     c_tag_in,
    output logic [31:0]          c_word_in,
    output logic [BLOCK_W-1:0]   c_block_in,
    input  logic                 c_hit,
    input  logic                 c_dirty,
    input  logic                 c_word_valid,
    input  logic [31:0]          c_word_out,
    input  logic [BLOCK_W-1:0]   c_block_out,
    input  logic [TAG_W-1:0]     c_tag_out,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [BLOCK_W-1:0]   mem_wdata,
    input  logic [BLOCK_W-1:0]   mem_rdata,
    input  logic                 mem_ack,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count
);
    state_t             state_reg;
    logic [31:0]        wb_addr_reg;
    logic [BLOCK_W-1:0] wb_data_reg;
    logic               retry_reg;
    logic               idle_hit;
    logic               idle_miss;

    assign idle_hit  = (state_reg == IDLE) && cpu.cpu_req && c_hit && !reset;
    assign idle_miss = (state_reg == IDLE) && cpu.cpu_req && !c_hit && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            wb_addr_reg <= '0;
            wb_data_reg <= '0;
            retry_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cpu.cpu_req && c_hit) begin
                        retry_reg <= 1'b0;
                    end else if (cpu.cpu_req) begin
                        if (c_word_valid && c_dirty) begin
                            wb_data_reg <= c_block_out;
                            wb_addr_reg <= {c_tag_out, cpu.cpu_addr[INDEX_LSB +: INDEX_W], 4'b0000};
                            state_reg   <= WRITEBACK;
                        end else begin
                            state_reg <= FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) state_reg <= FILL;
                end
                FILL: begin
                    // The next IDLE hit finishes this miss and is not a new hit.
                    if (mem_ack) begin
                        state_reg <= IDLE;
                        retry_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        c_index       = cpu.cpu_addr[INDEX_LSB +: INDEX_W];
        c_word        = cpu.cpu_addr[WORD_LSB +: 2];
        c_byte        = cpu.cpu_addr[1:0];
        c_tag_in      = cpu.cpu_addr[TAG_LSB +: TAG_W];
        c_word_in     = cpu.cpu_wdata;
        c_byte_access = cpu.cpu_byte;
        c_block_in    = mem_rdata;
        cpu.cpu_rdata = c_word_out;
        cpu.cpu_ready = idle_hit;
        c_write_word  = idle_hit && cpu.cpu_we;
        c_write_block = (state_reg == FILL) && mem_ack && !reset;
        mem_req       = (state_reg != IDLE) && !reset;
        mem_we        = (state_reg == WRITEBACK);
        mem_addr      = (state_reg == WRITEBACK) ? wb_addr_reg : block_addr(cpu.cpu_addr);
        mem_wdata     = wb_data_reg;
    end

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (idle_hit && !retry_reg),
        .value (hit_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (idle_miss),
        .value (miss_count)
    );
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequences the 4-line, 4-word-per-line direct-mapped write-back cache between the CPU load/store port and the 128-bit main-memory block interface.
- Decodes CPU addresses into tag/index/word/byte and drives the cache's write_word/write_block controls.
- On a miss, runs dirty writeback then block fill, holding the CPU stalled until the access hits.
- Counts hits and misses for performance monitoring; lives alongside the cache at the memory-stage boundary.

Parameters:
- CNT_W, 16, width of the saturating hit/miss counters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; also routed to the cache's reset
- cpu_req  in  1  access request; CPU holds all cpu_* inputs stable until cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_byte  in  1  byte access (load zero-extends)
- cpu_addr  in  32  [31:6] tag, [5:4] index, [3:2] word, [1:0] byte
- cpu_wdata  in  32  store data (byte store uses [7:0])
- cpu_rdata  out  32  load data (cache word_out)
- cpu_ready  out  1  access completes this cycle
- c_write_word, c_write_block, c_byte_access  out  1  cache controls
- c_index, c_word, c_byte  out  2  cache select fields
- c_tag_in  out  26  cache tag input
- c_word_in  out  32  cache word data
- c_block_in  out  128  cache fill data
- c_hit, c_dirty, c_word_valid  in  1  cache status
- c_word_out  in  32  cache read word
- c_block_out  in  128  victim block
- c_tag_out  in  26  victim tag
- mem_req  out  1  memory request
- mem_we  out  1  1 = block write (writeback), 0 = block read (fill)
- mem_addr  out  32  block-aligned address, [3:0] = 0
- mem_wdata  out  128  writeback data
- mem_rdata  in  128  fill data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- hit_count, miss_count  out  CNT_W  saturating performance counters

Behaviour:
- Reset, in any state:
  - Next state IDLE; hit_count and miss_count cleared to 0.
  - During the reset cycle: mem_req, cpu_ready and all c_write_* are 0.
  - An outstanding memory transaction is abandoned; memory drops it when mem_req falls.
- Address fields are driven combinationally from cpu_addr in every state; the CPU hold rule keeps them stable.
- States: IDLE, WRITEBACK, FILL.
- IDLE:
  - cpu_req=0: no action.
  - cpu_req=1 and c_hit=1: cpu_ready=1 in the same cycle (zero-latency hit); hit_count increments.
    - Load: cpu_rdata = c_word_out.
    - Store: c_write_word=1, c_word_in=cpu_wdata, c_byte_access=cpu_byte; the cache sets the line dirty.
  - cpu_req=1 and c_hit=0: cpu_ready=0; miss_count increments once per miss.
    - Victim valid and dirty (c_word_valid & c_dirty): next state WRITEBACK. Capture c_block_out and {c_tag_out, index, 4'b0} into registers.
    - Otherwise: next state FILL.
- WRITEBACK:
  - mem_req=1, mem_we=1; mem_addr and mem_wdata come from the captured registers and stay stable.
  - On mem_ack: next state FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = {cpu_addr[31:4], 4'b0}.
  - On mem_ack: c_write_block=1 and c_block_in=mem_rdata in that cycle; next state IDLE.
  - The re-lookup in IDLE then hits and completes the access. Stores are write-allocate: fill first, then the word write.
- mem_req deasserts the cycle after mem_ack. mem_ack while mem_req=0 is ignored.
- c_write_word and c_write_block are never asserted in the same cycle.
- Minimum latencies:
  - Clean miss: 2 + memory latency cycles.
  - Dirty miss: adds one more memory transaction.
- Counters saturate at all-ones and do not wrap.

Decomposition:
- cache_ctrl_pkg holds:
  - state enum (IDLE, WRITEBACK, FILL);
  - TAG_W=26, INDEX_W=2, BLOCK_W=128;
  - address slice constants TAG_LSB=6, INDEX_LSB=4, WORD_LSB=2.
- Sub-module: sat_counter (CNT_W, clock, reset, inc, value), instantiated twice.
- The cache itself is instantiated by the parent, not inside this block.

Test Plan:
- Cold load 0x0000_0040 after reset:
  - Expect mem_req=1, mem_we=0, mem_addr=0x40.
  - Ack after 3 cycles with mem_rdata word0=0x1111_1111.
  - Expect cpu_ready the following cycle, cpu_rdata=0x1111_1111, miss_count=1.
- Load 0x0000_0048 after scenario 1: cpu_ready in the same cycle, data = word2 of the fill, hit_count=1, no mem_req.
- Byte store 0xAB to 0x0000_0041, then load 0x0000_0140 (index 0, new tag):
  - Expect WRITEBACK with mem_we=1, mem_addr=0x40, mem_wdata[15:8]=0xAB.
  - After ack, expect FILL with mem_addr=0x140.
- Reset asserted mid-FILL with no ack:
  - Expect mem_req=0 in the reset cycle and state IDLE.
  - Expect counters 0; the next load of 0x40 misses again.
- Spurious mem_ack pulse in IDLE with cpu_req=0: no state change, no c_write_block.
- Force hit_count to all-ones-1, then perform 2 hits: value holds at all-ones.
